// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite sequencer: character states,
// sprite codes, default keycodes and the state-to-sprite mapping.
package sprite_pkg;

  typedef enum logic [4:0] {
    ST,
    IH1, IH2, IH3, IH4, IH5,
    IS1, IS2, IS3, IS4, IS5,
    F1, F2, F3, F4,
    P1, P2, P3, P4,
    D
  } state_t;

  typedef enum logic [2:0] {
    K_NONE, K_HIGH, K_LOW, K_FWD, K_BACK, K_DUCK
  } key_t;

  localparam logic [7:0] SPR_ST  = 8'd0;
  localparam logic [7:0] SPR_IH1 = 8'd1,  SPR_IH2 = 8'd2,  SPR_IH3 = 8'd3,  SPR_IH4 = 8'd4,  SPR_IH5 = 8'd5;
  localparam logic [7:0] SPR_IS1 = 8'd6,  SPR_IS2 = 8'd7,  SPR_IS3 = 8'd8,  SPR_IS4 = 8'd9,  SPR_IS5 = 8'd10;
  localparam logic [7:0] SPR_F1  = 8'd11, SPR_F2  = 8'd12, SPR_F3  = 8'd13, SPR_F4  = 8'd14;
  localparam logic [7:0] SPR_P1  = 8'd15, SPR_P2  = 8'd16, SPR_P3  = 8'd17, SPR_P4  = 8'd18;
  localparam logic [7:0] SPR_D   = 8'd19;

  localparam logic [7:0] DEF_KEY_HIGH = 8'h1A;
  localparam logic [7:0] DEF_KEY_LOW  = 8'h16;
  localparam logic [7:0] DEF_KEY_FWD  = 8'h07;
  localparam logic [7:0] DEF_KEY_BACK = 8'h04;
  localparam logic [7:0] DEF_KEY_DUCK = 8'h1D;

  function automatic logic [7:0] state_to_sprite(input state_t s);
    case (s)
      IH1:     return SPR_IH1;
      IH2:     return SPR_IH2;
      IH3:     return SPR_IH3;
      IH4:     return SPR_IH4;
      IH5:     return SPR_IH5;
      IS1:     return SPR_IS1;
      IS2:     return SPR_IS2;
      IS3:     return SPR_IS3;
      IS4:     return SPR_IS4;
      IS5:     return SPR_IS5;
      F1:      return SPR_F1;
      F2:      return SPR_F2;
      F3:      return SPR_F3;
      F4:      return SPR_F4;
      P1:      return SPR_P1;
      P2:      return SPR_P2;
      P3:      return SPR_P3;
      P4:      return SPR_P4;
      D:       return SPR_D;
      default: return SPR_ST;
    endcase
  endfunction

  function automatic logic is_attack(input state_t s);
    return (s >= IH1) && (s <= IS5);
  endfunction

endpackage

// File: rtl/sprite_sequencer_frame_tick_gen.sv
// Brings the asynchronous active-low vsync into the Clk domain and emits a
// registered one-cycle pulse at the end of each sync pulse (rising edge).
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vs,
  output logic frame_tick
);

  logic vs_s1, vs_s2, vs_d;

  // Flops reset high so an idle (high) vsync never produces a tick on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_s1      <= 1'b1;
      vs_s2      <= 1'b1;
      vs_d       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      vs_s1      <= vs;
      vs_s2      <= vs_s1;
      vs_d       <= vs_s2;
      frame_tick <= vs_s2 & ~vs_d;
    end
  end

endmodule

// File: rtl/sprite_sequencer.sv
// Frame-synchronous character animation FSM: steps once per frame_tick,
// attacks run to completion, walk/duck follow the held key.
module sprite_sequencer
  import sprite_pkg::*;
#(
  parameter int         HOLD_FRAMES = 4,
  parameter logic [7:0] KEY_HIGH    = DEF_KEY_HIGH,
  parameter logic [7:0] KEY_LOW     = DEF_KEY_LOW,
  parameter logic [7:0] KEY_FWD     = DEF_KEY_FWD,
  parameter logic [7:0] KEY_BACK    = DEF_KEY_BACK,
  parameter logic [7:0] KEY_DUCK    = DEF_KEY_DUCK
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic [7:0] keycode,
  output logic [7:0] Sprite,
  output logic       busy,
  output logic       frame_tick,
  output logic [4:0] state_dbg
);

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  state_t          state, state_next;
  key_t            key;
  logic [HW-1:0]   hold_cnt;
  logic            step;

  frame_tick_gen u_tick (
    .clk        (Clk),
    .rst        (Reset),
    .vs         (vs),
    .frame_tick (frame_tick)
  );

  assign state_dbg = state;
  assign step      = frame_tick && (hold_cnt == HW'(HOLD_FRAMES - 1));

  always_comb begin
    key = K_NONE;
    if      (keycode == KEY_HIGH) key = K_HIGH;
    else if (keycode == KEY_LOW)  key = K_LOW;
    else if (keycode == KEY_FWD)  key = K_FWD;
    else if (keycode == KEY_BACK) key = K_BACK;
    else if (keycode == KEY_DUCK) key = K_DUCK;
  end

  // Keycode only matters in the frame_tick cycle; all transitions happen there.
  always_comb begin
    state_next = state;
    if (frame_tick) begin
      case (state)
        ST: begin
          case (key)
            K_HIGH:  state_next = IH1;
            K_LOW:   state_next = IS1;
            K_FWD:   state_next = F1;
            K_BACK:  state_next = P1;
            K_DUCK:  state_next = D;
            default: state_next = ST;
          endcase
        end
        IH1, IH2, IH3, IH4, IS1, IS2, IS3, IS4:
          if (step) state_next = state_t'(state + 5'd1);
        IH5, IS5:
          if (step) state_next = ST;
        F1, F2, F3, F4: begin
          if (key != K_FWD)   state_next = ST;
          else if (step)      state_next = (state == F4) ? F1 : state_t'(state + 5'd1);
        end
        P1, P2, P3, P4: begin
          if (key != K_BACK)  state_next = ST;
          else if (step)      state_next = (state == P4) ? P1 : state_t'(state + 5'd1);
        end
        D:
          if (key != K_DUCK) state_next = ST;
        default: state_next = ST;
      endcase
    end
  end

  // Holding the counter at zero while in ST makes every entry start a fresh hold.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= ST;
      hold_cnt <= '0;
      Sprite   <= SPR_ST;
      busy     <= 1'b0;
    end else begin
      state  <= state_next;
      Sprite <= state_to_sprite(state_next);
      busy   <= is_attack(state_next);
      if (frame_tick) begin
        if (step || state == ST) hold_cnt <= '0;
        else                     hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sprite_sequencer.sv
// Bench for sprite_sequencer: two instances (HOLD_FRAMES=4 and 1) share
// vsync/keycode and are compared frame by frame against an animation model.
module tb_sprite_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       vs;
  logic [7:0] keycode;
  logic [7:0] sprite0, sprite1;
  logic       busy0, busy1, ft0, ft1;
  logic [4:0] st_dbg0, st_dbg1;

  always #5 clk = ~clk;

  sprite_sequencer #(.HOLD_FRAMES(4)) u_dut (
    .Clk(clk), .Reset(rst), .vs(vs), .keycode(keycode),
    .Sprite(sprite0), .busy(busy0), .frame_tick(ft0), .state_dbg(st_dbg0)
  );

  sprite_sequencer #(.HOLD_FRAMES(1)) u_dut1 (
    .Clk(clk), .Reset(rst), .vs(vs), .keycode(keycode),
    .Sprite(sprite1), .busy(busy1), .frame_tick(ft1), .state_dbg(st_dbg1)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];   // {busy, sprite}, dut0 then dut1 per frame

  // Reference model: animation kind, frame index within it, frames shown.
  localparam int M_NONE = 0, M_HIGH = 1, M_LOW = 2, M_FWD = 3, M_BACK = 4, M_DUCK = 5;
  int m_mode[2];
  int m_idx[2];
  int m_cnt[2];
  int hold_of[2] = '{4, 1};

  logic [3:0] obs_ft[2];
  logic [8:0] obs[2];

  function automatic int key_mode(input logic [7:0] k);
    case (k)
      8'h1A:   return M_HIGH;
      8'h16:   return M_LOW;
      8'h07:   return M_FWD;
      8'h04:   return M_BACK;
      8'h1D:   return M_DUCK;
      default: return M_NONE;
    endcase
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_mode[u] = M_NONE; m_idx[u] = 0; m_cnt[u] = 0;
    end
  endtask

  task automatic model_tick(input int u, input logic [7:0] key);
    int k;
    k = key_mode(key);
    case (m_mode[u])
      M_NONE:
        if (k != M_NONE) begin m_mode[u] = k; m_idx[u] = 0; m_cnt[u] = 0; end
      M_HIGH, M_LOW: begin
        m_cnt[u]++;
        if (m_cnt[u] == hold_of[u]) begin
          m_cnt[u] = 0; m_idx[u]++;
          if (m_idx[u] == 5) m_mode[u] = M_NONE;
        end
      end
      M_FWD, M_BACK: begin
        if (k != m_mode[u]) m_mode[u] = M_NONE;
        else begin
          m_cnt[u]++;
          if (m_cnt[u] == hold_of[u]) begin m_cnt[u] = 0; m_idx[u] = (m_idx[u] + 1) % 4; end
        end
      end
      default:
        if (k != M_DUCK) m_mode[u] = M_NONE;
    endcase
  endtask

  function automatic logic [8:0] model_out(input int u);
    logic [7:0] s;
    case (m_mode[u])
      M_HIGH:  s = 8'(1 + m_idx[u]);
      M_LOW:   s = 8'(6 + m_idx[u]);
      M_FWD:   s = 8'(11 + m_idx[u]);
      M_BACK:  s = 8'(15 + m_idx[u]);
      M_DUCK:  s = 8'd19;
      default: s = 8'd0;
    endcase
    return {(m_mode[u] == M_HIGH || m_mode[u] == M_LOW), s};
  endfunction

  // One vsync pulse: junk on keycode while vs is low, real key from the rising edge.
  task automatic do_frame(input logic [7:0] key, input logic [7:0] junk);
    @(negedge clk);
    keycode = junk;
    vs = 1'b0;
    repeat ($urandom_range(2, 5)) @(negedge clk);
    keycode = key;
    vs = 1'b1;
    obs_ft[0] = '0;
    obs_ft[1] = '0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      obs_ft[0][e] = ft0;
      obs_ft[1][e] = ft1;
    end
    obs[0] = {busy0, sprite0};
    obs[1] = {busy1, sprite1};
    for (int u = 0; u < 2; u++) begin
      model_tick(u, key);
      exp_q.push_back(model_out(u));
    end
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    rst = 1'b1; vs = 1'b1; keycode = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy0, sprite0, ft0, st_dbg0} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_dut0: busy=%0b sprite=%0d tick=%0b state=%0d, expected all 0", busy0, sprite0, ft0, st_dbg0);
    end
    n_vec++;
    if ({busy1, sprite1, ft1, st_dbg1} !== 15'd0) begin
      n_err++;
      $display("FAIL reset_dut1: busy=%0b sprite=%0d tick=%0b state=%0d, expected all 0", busy1, sprite1, ft1, st_dbg1);
    end
    rst = 1'b0;
    // Walk forward into F3 on dut0, then reset asynchronously.
    for (int f = 0; f < 9; f++) begin
      do_frame(8'h07, 8'($urandom));
      for (int u = 0; u < 2; u++) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (obs[u] !== exp) begin
          n_err++;
          $display("FAIL reset_walk dut%0d frame %0d: busy/sprite=%0b/%0d, expected %0b/%0d", u, f, obs[u][8], obs[u][7:0], exp[8], exp[7:0]);
        end
      end
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({busy0, sprite0} !== 9'd0) begin
      n_err++;
      $display("FAIL async_reset: busy=%0b sprite=%0d, expected 0/0", busy0, sprite0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    n_vec++;
    if ({busy0, sprite0, busy1, sprite1} !== 18'd0) begin
      n_err++;
      $display("FAIL after_release: sprite0=%0d sprite1=%0d, expected 0", sprite0, sprite1);
    end
    for (int f = 0; f < 3; f++) begin
      do_frame(8'h00, 8'($urandom));
      for (int u = 0; u < 2; u++) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (obs[u] !== exp) begin
          n_err++;
          $display("FAIL idle_after_reset dut%0d frame %0d: busy/sprite=%0b/%0d, expected %0b/%0d", u, f, obs[u][8], obs[u][7:0], exp[8], exp[7:0]);
        end
      end
    end
  endtask

  task automatic test_high_attack();
    logic [8:0] exp;
    for (int f = 0; f < 21; f++) begin
      do_frame((f == 0) ? 8'h1A : ((f >= 5 && f <= 8) ? 8'h07 : 8'h00), 8'($urandom));
      for (int u = 0; u < 2; u++) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (obs[u] !== exp) begin
          n_err++;
          $display("FAIL high_attack dut%0d frame %0d: busy/sprite=%0b/%0d, expected %0b/%0d", u, f, obs[u][8], obs[u][7:0], exp[8], exp[7:0]);
        end
      end
    end
  endtask

  task automatic test_walk();
    logic [8:0] exp;
    for (int f = 0; f < 23; f++) begin
      do_frame((f < 20) ? 8'h07 : 8'h00, 8'($urandom));
      for (int u = 0; u < 2; u++) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (obs[u] !== exp) begin
          n_err++;
          $display("FAIL walk dut%0d frame %0d: busy/sprite=%0b/%0d, expected %0b/%0d", u, f, obs[u][8], obs[u][7:0], exp[8], exp[7:0]);
        end
      end
    end
  endtask

  task automatic test_duck();
    logic [8:0] exp;
    logic [7:0] keys [6];
    keys = '{8'h1D, 8'h1D, 8'h1D, 8'h04, 8'h04, 8'h00};
    for (int f = 0; f < 6; f++) begin
      do_frame(keys[f], 8'($urandom));
      for (int u = 0; u < 2; u++) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (obs[u] !== exp) begin
          n_err++;
          $display("FAIL duck dut%0d frame %0d: busy/sprite=%0b/%0d, expected %0b/%0d", u, f, obs[u][8], obs[u][7:0], exp[8], exp[7:0]);
        end
      end
    end
  endtask

  task automatic test_toggle();
    logic [8:0] exp;
    for (int f = 0; f < 4; f++) begin
      do_frame(8'h00, (f % 2 == 0) ? 8'h1A : 8'h07);
      for (int u = 0; u < 2; u++) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (obs[u] !== exp) begin
          n_err++;
          $display("FAIL toggle dut%0d frame %0d: busy/sprite=%0b/%0d, expected %0b/%0d", u, f, obs[u][8], obs[u][7:0], exp[8], exp[7:0]);
        end
        n_vec++;
        if (obs_ft[u] !== 4'b0100) begin
          n_err++;
          $display("FAIL tick_timing dut%0d frame %0d: tick after edges 4..1=%b, expected 0100", u, f, obs_ft[u]);
        end
      end
    end
  endtask

  task automatic test_hold1();
    logic [8:0] exp;
    for (int f = 0; f < 7; f++) begin
      do_frame((f == 0) ? 8'h16 : 8'h00, 8'($urandom));
      for (int u = 0; u < 2; u++) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (obs[u] !== exp) begin
          n_err++;
          $display("FAIL hold1_low dut%0d frame %0d: busy/sprite=%0b/%0d, expected %0b/%0d", u, f, obs[u][8], obs[u][7:0], exp[8], exp[7:0]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] exp;
    logic [7:0] key;
    logic [7:0] table_k [7];
    table_k = '{8'h00, 8'h1A, 8'h16, 8'h07, 8'h04, 8'h1D, 8'h55};
    key = 8'h00;
    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 9) >= 7) key = table_k[$urandom_range(0, 6)];
      do_frame(key, 8'($urandom));
      for (int u = 0; u < 2; u++) begin
        exp = exp_q.pop_front();
        n_vec++;
        if (obs[u] !== exp) begin
          n_err++;
          $display("FAIL random dut%0d frame %0d key %h: busy/sprite=%0b/%0d, expected %0b/%0d", u, f, key, obs[u][8], obs[u][7:0], exp[8], exp[7:0]);
        end
        n_vec++;
        if (obs_ft[u] !== 4'b0100) begin
          n_err++;
          $display("FAIL random_tick dut%0d frame %0d: tick after edges 4..1=%b, expected 0100", u, f, obs_ft[u]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_high_attack();
    test_walk();
    test_duck();
    test_toggle();
    test_hold1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
